// File: rtl/hs32_mem_arb_pkg.sv
// hs32_mem_arb shared definitions: arbiter state encoding and
// port-select constants, also used by the pipeline controller.
package hs32_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_E = 2'd2
   } arb_state_e;

   localparam logic PORT_F = 1'b0;
   localparam logic PORT_E = 1'b1;

endpackage

// File: rtl/hs32_mem_arb_if.sv
// hs32_mem_arb bus bundle: fetch port, execute port and memory port.
// master is the arbiter view, slave is the core/memory view.
interface hs32_mem_arb_if;

   logic [31:0] addrf;
   logic        reqf;
   logic [31:0] dtrf;
   logic        rdyf;

   logic [31:0] addre;
   logic [31:0] dtwe;
   logic        rwe;
   logic        reqe;
   logic [31:0] dtre;
   logic        rdye;

   logic [31:0] mem_addr;
   logic [31:0] mem_dtw;
   logic        mem_rw;
   logic        mem_req;
   logic [31:0] mem_dtr;
   logic        mem_rdy;

   modport master (
      input  addrf, reqf,
      input  addre, dtwe, rwe, reqe,
      input  mem_dtr, mem_rdy,
      output dtrf, rdyf,
      output dtre, rdye,
      output mem_addr, mem_dtw,
      output mem_rw, mem_req
   );

   modport slave (
      output addrf, reqf,
      output addre, dtwe, rwe, reqe,
      output mem_dtr, mem_rdy,
      input  dtrf, rdyf,
      input  dtre, rdye,
      input  mem_addr, mem_dtw,
      input  mem_rw, mem_req
   );

endinterface

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: serializes fetch (read) and execute (read/write)
// word requests onto one memory port with alternating tie-break.
module hs32_mem_arb
   import hs32_mem_arb_pkg::*;
(
   input  logic           clk,
   input  logic           rstn,
   hs32_mem_arb_if.master bus
);

   arb_state_e  state_q;
   logic        last_q;
   logic [31:0] addr_q;
   logic [31:0] dtw_q;
   logic        rw_q;
   logic        req_q;
   logic        grant_e;

   // On a tie, execute wins unless it was the last port served.
   assign grant_e = bus.reqe &&
                    (!bus.reqf || last_q == PORT_F);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         last_q  <= PORT_F;
         addr_q  <= '0;
         dtw_q   <= '0;
         rw_q    <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_e) begin
                  state_q <= BUSY_E;
                  addr_q  <= bus.addre;
                  dtw_q   <= bus.dtwe;
                  rw_q    <= bus.rwe;
                  req_q   <= 1'b1;
               end else if (bus.reqf) begin
                  state_q <= BUSY_F;
                  addr_q  <= bus.addrf;
                  dtw_q   <= '0;
                  rw_q    <= 1'b0;
                  req_q   <= 1'b1;
               end
            end
            BUSY_F: begin
               if (bus.mem_rdy) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  last_q  <= PORT_F;
               end
            end
            BUSY_E: begin
               if (bus.mem_rdy) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  last_q  <= PORT_E;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_addr = addr_q;
   assign bus.mem_dtw  = dtw_q;
   assign bus.mem_rw   = rw_q;
   assign bus.mem_req  = req_q;

   // Completion is combinational from mem_rdy so no cycle is lost.
   assign bus.rdyf = (state_q == BUSY_F) && bus.mem_rdy;
   assign bus.rdye = (state_q == BUSY_E) && bus.mem_rdy;
   assign bus.dtrf = bus.mem_dtr;
   assign bus.dtre = bus.mem_dtr;

`ifdef FORMAL
   a_hold: assert property (
      @(posedge clk) disable iff (!rstn)
      req_q && !bus.mem_rdy |=>
      $stable(addr_q) && $stable(dtw_q) &&
      $stable(rw_q) && req_q);

   a_onehot: assert property (
      @(posedge clk) !(bus.rdyf && bus.rdye));

   m_rdy: assume property (
      @(posedge clk) disable iff (!rstn)
      req_q |-> s_eventually bus.mem_rdy);

   a_done: assert property (
      @(posedge clk) disable iff (!rstn)
      req_q |-> s_eventually !req_q);
`endif

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb: single ports, contention,
// back-to-back fetch, dropped request and reset abort.
module tb_hs32_mem_arb;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   fill = 0;

   hs32_mem_arb_if bus ();

   hs32_mem_arb dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   initial begin
      bus.addrf   = '0;
      bus.reqf    = 1'b0;
      bus.addre   = '0;
      bus.dtwe    = '0;
      bus.rwe     = 1'b0;
      bus.reqe    = 1'b0;
      bus.mem_dtr = '0;
      bus.mem_rdy = 1'b1;

      // reset state; mem_rdy high must not leak to rdy
      repeat (2) @(posedge clk);
      smp;
      chk("rst_req", bus.mem_req, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_dtw", bus.mem_dtw, 0);
      chk("rst_rw", bus.mem_rw, 0);
      chk("rst_rdyf", bus.rdyf, 0);
      chk("rst_rdye", bus.rdye, 0);

      // contention from reset: E,F,E,F,E,F
      step;
      rstn = 1'b1;
      bus.mem_rdy = 1'b0;
      bus.reqf  = 1'b1;
      bus.reqe  = 1'b1;
      bus.addrf = 32'h10;
      bus.addre = 32'h20;
      for (int i = 0; i < 6; i++) begin
         logic e;
         e = (i % 2 == 0);
         step;
         bus.mem_rdy = 1'b1;
         bus.mem_dtr = 32'hC0 + i;
         smp;
         chk("cont_addr", bus.mem_addr,
             e ? 32'h20 : 32'h10);
         chk("cont_rdye", bus.rdye, e);
         chk("cont_rdyf", bus.rdyf, !e);
         step;
         bus.mem_rdy = 1'b0;
         if (i == 5) begin
            bus.reqf = 1'b0;
            bus.reqe = 1'b0;
         end
         smp;
         chk("cont_idle", bus.mem_req, 0);
      end

      // fetch only, memory two cycles late
      step;
      bus.reqf  = 1'b1;
      bus.addrf = 32'h100;
      step;
      smp;
      chk("f_req", bus.mem_req, 1);
      chk("f_addr", bus.mem_addr, 32'h100);
      chk("f_rw", bus.mem_rw, 0);
      chk("f_dtw", bus.mem_dtw, 0);
      step;
      smp;
      chk("f_wait_rdyf", bus.rdyf, 0);
      chk("f_hold_addr", bus.mem_addr, 32'h100);
      step;
      bus.mem_rdy = 1'b1;
      bus.mem_dtr = 32'hDEADBEEF;
      smp;
      chk("f_rdyf", bus.rdyf, 1);
      chk("f_dtrf", bus.dtrf, 32'hDEADBEEF);
      chk("f_rdye", bus.rdye, 0);
      step;
      bus.mem_rdy = 1'b0;
      bus.reqf = 1'b0;
      smp;
      chk("f_rdyf_end", bus.rdyf, 0);
      chk("f_req_end", bus.mem_req, 0);

      // dropped fetch request still completes
      step;
      bus.reqf  = 1'b1;
      bus.addrf = 32'h300;
      step;
      bus.reqf = 1'b0;
      smp;
      chk("d_req", bus.mem_req, 1);
      chk("d_addr", bus.mem_addr, 32'h300);
      step;
      bus.mem_rdy = 1'b1;
      bus.mem_dtr = 32'h33;
      smp;
      chk("d_rdyf", bus.rdyf, 1);
      step;
      bus.mem_rdy = 1'b0;
      smp;
      chk("d_idle", bus.mem_req, 0);
      chk("d_rdyf_end", bus.rdyf, 0);

      // mem_rdy in IDLE is ignored
      step;
      bus.mem_rdy = 1'b1;
      smp;
      chk("i_rdyf", bus.rdyf, 0);
      chk("i_rdye", bus.rdye, 0);
      chk("i_req", bus.mem_req, 0);

      // back-to-back fetch, zero-wait, data = addr+1
      step;
      bus.mem_rdy = 1'b0;
      bus.reqf  = 1'b1;
      bus.addrf = 32'h0;
      for (int i = 0; i < 4; i++) begin
         step;
         bus.mem_rdy = 1'b1;
         bus.mem_dtr = 32'(4 * i + 1);
         smp;
         chk("b_addr", bus.mem_addr, 32'(4 * i));
         chk("b_rdyf", bus.rdyf, 1);
         chk("b_dtrf", bus.dtrf, 32'(4 * i + 1));
         if (bus.rdyf === 1'b1) fill++;
         step;
         bus.mem_rdy = 1'b0;
         bus.addrf = 32'(4 * (i + 1));
         if (i == 3) bus.reqf = 1'b0;
         smp;
         chk("b_idle", bus.mem_req, 0);
      end
      step;
      smp;
      chk("b_nogrant", bus.mem_req, 0);
      chk("b_fill", fill, 4);

      // execute write, held until mem_rdy
      step;
      bus.reqe  = 1'b1;
      bus.rwe   = 1'b1;
      bus.addre = 32'h200;
      bus.dtwe  = 32'h12345678;
      step;
      smp;
      chk("e_req", bus.mem_req, 1);
      chk("e_rw", bus.mem_rw, 1);
      chk("e_dtw", bus.mem_dtw, 32'h12345678);
      chk("e_addr", bus.mem_addr, 32'h200);
      step;
      smp;
      chk("e_hold_dtw", bus.mem_dtw, 32'h12345678);
      chk("e_hold_rw", bus.mem_rw, 1);
      chk("e_wait_rdye", bus.rdye, 0);
      step;
      bus.mem_rdy = 1'b1;
      smp;
      chk("e_rdye", bus.rdye, 1);
      chk("e_rdyf", bus.rdyf, 0);
      step;
      bus.mem_rdy = 1'b0;
      bus.reqe = 1'b0;
      bus.rwe  = 1'b0;
      smp;
      chk("e_rdye_end", bus.rdye, 0);
      chk("e_req_end", bus.mem_req, 0);

      // reset in BUSY_E aborts without a pulse
      step;
      bus.reqe  = 1'b1;
      bus.rwe   = 1'b1;
      bus.addre = 32'h400;
      bus.dtwe  = 32'hAAAA5555;
      step;
      smp;
      chk("r_req", bus.mem_req, 1);
      chk("r_rw", bus.mem_rw, 1);
      rstn = 1'b0;
      bus.mem_rdy = 1'b1;
      #1;
      chk("r_req0", bus.mem_req, 0);
      chk("r_addr0", bus.mem_addr, 0);
      chk("r_dtw0", bus.mem_dtw, 0);
      chk("r_rw0", bus.mem_rw, 0);
      chk("r_rdye0", bus.rdye, 0);
      step;
      bus.mem_rdy = 1'b0;
      step;
      rstn = 1'b1;
      bus.reqf  = 1'b1;
      bus.addrf = 32'h500;
      bus.addre = 32'h600;
      bus.rwe   = 1'b0;
      step;
      smp;
      chk("r_first_e", bus.mem_addr, 32'h600);
      chk("r_first_rw", bus.mem_rw, 0);
      step;
      bus.mem_rdy = 1'b1;
      smp;
      chk("r_rdye", bus.rdye, 1);
      chk("r_rdyf", bus.rdyf, 0);
      step;
      bus.mem_rdy = 1'b0;
      bus.reqf = 1'b0;
      bus.reqe = 1'b0;
      smp;
      chk("r_idle", bus.mem_req, 0);

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
